// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: WIDTH-step restoring divider controller with start/ready handshake and divide-by-zero detect.
// Define SIGNED_DIV_EN for two's-complement operands; unsigned-only when undefined.
module div_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_q, r_quot, r_rem;
    logic [WIDTH:0]   r_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dz;
    logic [WIDTH:0]   w_rs, w_t, w_rn;
    logic [WIDTH-1:0] w_qn, w_qf, w_rf, w_amag, w_bmag;
    logic             w_last;

`ifdef SIGNED_DIV_EN
    logic r_sb;
    assign w_amag = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_bmag = r_b[WIDTH-1] ? -r_b : r_b;
    assign w_qf   = (r_a[WIDTH-1] ^ r_sb) ? -w_qn : w_qn;
    assign w_rf   = r_a[WIDTH-1] ? -w_rn[WIDTH-1:0] : w_rn[WIDTH-1:0];

    // divisor sign must survive LOAD, which overwrites r_b with its magnitude
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_sb <= 1'b0;
        else if (r_state == IDLE && start)
            r_sb <= divisor[WIDTH-1];
    end
`else
    assign w_amag = r_a;
    assign w_bmag = r_b;
    assign w_qf   = w_qn;
    assign w_rf   = w_rn[WIDTH-1:0];
`endif

    assign w_last    = r_cnt == CNT_W'(WIDTH - 1);
    assign ready     = r_state == IDLE;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_dz;

    // one restoring step: shift {R,Q}, trial subtract, keep or restore
    always_comb begin
        w_rs = (WIDTH + 1)'({r_r, r_q[WIDTH-1]});
        w_t  = w_rs - {1'b0, r_b};
        w_rn = w_t[WIDTH] ? w_rs : w_t;
        w_qn = {r_q[WIDTH-2:0], ~w_t[WIDTH]};
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next-state sequencing
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? LOAD : IDLE;
            LOAD:    w_next = (r_b == '0) ? DONE : ITER;
            ITER:    w_next = w_last ? DONE : ITER;
            default: w_next = IDLE;
        endcase
    end

    // operand capture, iteration state and result registers loaded on entry to DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_a <= dividend;
                r_b <= divisor;
            end
        end else if (r_state == LOAD) begin
            r_r   <= '0;
            r_q   <= w_amag;
            r_b   <= w_bmag;
            r_cnt <= '0;
            if (r_b == '0) begin
                r_quot <= '1;
                r_rem  <= r_a;
                r_dz   <= 1'b1;
            end
        end else if (r_state == ITER) begin
            r_r   <= w_rn;
            r_q   <= w_qn;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_quot <= w_qf;
                r_rem  <= w_rf;
                r_dz   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: scoreboard bench for div_seq_ctrl (unsigned, or signed with SIGNED_DIV_EN).
module tb_div_seq_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready, busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .ready(ready), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa, sbv, qm, rm;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
            return e;
        end
`ifdef SIGNED_DIV_EN
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        qm  = (sa < 0 ? -sa : sa) / (sbv < 0 ? -sbv : sbv);
        rm  = (sa < 0 ? -sa : sa) % (sbv < 0 ? -sbv : sbv);
        e.q = W'(((sa < 0) != (sbv < 0)) ? -qm : qm);
        e.r = W'((sa < 0) ? -rm : rm);
`else
        sa = int'(a); sbv = int'(b);
        qm = sa / sbv; rm = sa % sbv;
        e.q = W'(qm);
        e.r = W'(rm);
`endif
        e.dz = 1'b0;
        return e;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
        end
        n_checks++;
        if (k == 40) begin
            n_fail++;
            $display("FAIL start_wait: ready=%b required 1 within 40 cycles", ready);
        end
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   lat;
        int   exp_lat;
        exp_lat = (b == '0) ? 2 : 18;
        sb.push_back(model(a, b));
        start_op(a, b);
        wait_done(lat);
        e = sb.pop_front();
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL latency %h/%h: got %0d required %0d", a, b, lat, exp_lat);
        end
        n_checks++;
        if ({quotient, remainder, div_zero} !== e) begin
            n_fail++;
            $display("FAIL result %h/%h: got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                     a, b, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_done %h/%h: got ready=%b done=%b required 1 0", a, b, ready, done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        n_checks++;
        if (quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_results: got q=%h r=%h dz=%b required 0 0 0", quotient, remainder, div_zero);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_div(16'd100, 16'd7);
        n_checks++;
        if (quotient !== 16'd14 || remainder !== 16'd2) begin
            n_fail++;
            $display("FAIL basic_known: got q=%0d r=%0d required 14 2", quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        run_div(16'd1234, 16'd0);
    endtask

    task automatic test_boundary();
        run_div(16'hFFFF, 16'd1);
        run_div(16'd5, 16'd9);
        run_div(16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   lat;
        int   d0;
        d0 = done_cnt;
        sb.push_back(model(16'd100, 16'd7));
        start_op(16'd100, 16'd7);
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_flags: got busy=%b ready=%b required 1 0", busy, ready);
        end
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        e = sb.pop_front();
        n_checks++;
        if (lat < 0 || {quotient, remainder, div_zero} !== e) begin
            n_fail++;
            $display("FAIL busy_result: got q=%h r=%h dz=%b lat=%0d required q=%h r=%h dz=%b",
                     quotient, remainder, div_zero, lat, e.q, e.r, e.dz);
        end
        repeat (25) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL busy_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_abort();
        int d0;
        start_op(16'd100, 16'd7);
        repeat (9) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
                quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_in_reset: got rdy=%b busy=%b done=%b q=%h r=%h dz=%b required 1 0 0 0 0 0",
                         ready, busy, done, quotient, remainder, div_zero);
            end
        end
        rst = 1'b1;
        repeat (25) @(negedge clk);
        n_checks++;
        if (done_cnt !== d0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0);
        end
        run_div(16'd9, 16'd3);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
            run_div(a, b);
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        run_div(16'hFF9C, 16'd7);
        n_checks++;
        if (quotient !== 16'hFFF2 || remainder !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL signed_neg: got q=%h r=%h required FFF2 FFFE", quotient, remainder);
        end
        run_div(16'h8000, 16'hFFFF);
        n_checks++;
        if (quotient !== 16'h8000 || remainder !== 16'h0000) begin
            n_fail++;
            $display("FAIL signed_wrap: got q=%h r=%h required 8000 0000", quotient, remainder);
        end
        run_div(16'd100, 16'hFFF9);
        run_div(16'hFF9C, 16'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundary();
        test_busy_ignore();
        test_reset_abort();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
